digital_clock_hms: RTL and testbench

DIGITAL_CLOCK_HMS -- requirements
Module: digital_clock_hms

---
 rtl/digital_clock_pkg.sv | 15 +
 rtl/mod_counter.sv | 25 ++
 rtl/digital_clock_hms.sv | 84 ++++++++
 tb/tb_digital_clock_hms.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/digital_clock_pkg.sv
// Shared field widths, limits and the packed time-of-day struct for the HMS clock.
`timescale 1ns/1ps
package digital_clock_pkg;
  localparam int unsigned SEC_W  = 6;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned HOUR_W = 5;
  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

  typedef struct packed {
    logic [HOUR_W-1:0] hours;
    logic [MIN_W-1:0]  minutes;
    logic [SEC_W-1:0]  seconds;
  } time_t;
endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter with synchronous load; wrap flags the enabled step from N-1 to 0.
`timescale 1ns/1ps
module mod_counter #(
  parameter int unsigned MODULUS = 60,
  parameter int unsigned W       = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         wrap
);
  assign wrap = en && (count == W'(MODULUS - 1));

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en)
      count <= wrap ? '0 : count + 1'b1;
  end
endmodule

// File: rtl/digital_clock_hms.sv
// Hours/minutes/seconds clock with prescaler, validated load, day wrap and alarm pulses.
`timescale 1ns/1ps
module digital_clock_hms
  import digital_clock_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100,
  parameter int unsigned HOURS_PER_DAY = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              load,
  input  logic [HOUR_W-1:0] load_hours,
  input  logic [MIN_W-1:0]  load_minutes,
  input  logic [SEC_W-1:0]  load_seconds,
  input  logic              alarm_en,
  input  logic [HOUR_W-1:0] alarm_hours,
  input  logic [MIN_W-1:0]  alarm_minutes,
  output logic [SEC_W-1:0]  seconds,
  output logic [MIN_W-1:0]  minutes,
  output logic [HOUR_W-1:0] hours,
  output logic              sec_tick,
  output logic              day_tick,
  output logic              alarm,
  output logic              load_err
);
  localparam int unsigned PW = $clog2(TICKS_PER_SEC);

  logic [PW-1:0] presc;
  logic          load_ok, tick;
  logic          sec_wrap, min_wrap, hour_wrap;
  logic          alarm_hit;
  time_t         ld, now;
  logic [MIN_W-1:0]  next_min;
  logic [HOUR_W-1:0] next_hr;

  assign ld      = '{hours: load_hours, minutes: load_minutes, seconds: load_seconds};
  assign load_ok = load && (load_seconds <= SEC_MAX) && (load_minutes <= MIN_MAX)
                   && (load_hours < HOUR_W'(HOURS_PER_DAY));
  // Any load, even a rejected one, freezes the prescaler for that edge.
  assign tick    = run && !load && (presc == PW'(TICKS_PER_SEC - 1));

  mod_counter #(.MODULUS(60), .W(SEC_W)) u_sec (
    .clk(clk), .reset(reset), .en(tick), .load(load_ok),
    .load_val(ld.seconds), .count(now.seconds), .wrap(sec_wrap)
  );
  mod_counter #(.MODULUS(60), .W(MIN_W)) u_min (
    .clk(clk), .reset(reset), .en(sec_wrap), .load(load_ok),
    .load_val(ld.minutes), .count(now.minutes), .wrap(min_wrap)
  );
  mod_counter #(.MODULUS(HOURS_PER_DAY), .W(HOUR_W)) u_hour (
    .clk(clk), .reset(reset), .en(min_wrap), .load(load_ok),
    .load_val(ld.hours), .count(now.hours), .wrap(hour_wrap)
  );

  assign seconds = now.seconds;
  assign minutes = now.minutes;
  assign hours   = now.hours;

  // Alarm fires only on the tick that lands on hh:mm:00, i.e. when seconds wrap.
  assign next_min  = min_wrap ? '0 : now.minutes + 1'b1;
  assign next_hr   = hour_wrap ? '0 : (min_wrap ? now.hours + 1'b1 : now.hours);
  assign alarm_hit = alarm_en && sec_wrap && (next_min == alarm_minutes)
                     && (next_hr == alarm_hours);

  always_ff @(posedge clk) begin
    if (reset) begin
      presc    <= '0;
      sec_tick <= 1'b0;
      day_tick <= 1'b0;
      alarm    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      sec_tick <= tick;
      day_tick <= hour_wrap;
      alarm    <= alarm_hit;
      load_err <= load && !load_ok;
      if (load_ok)
        presc <= '0;
      else if (run && !load)
        presc <= tick ? '0 : presc + 1'b1;
    end
  end
endmodule

// File: tb/tb_digital_clock_hms.sv
// Scoreboard bench: a seconds-of-day reference model predicts every cycle for 24h and 12h clocks.
`timescale 1ns/1ps
module tb_digital_clock_hms;
  localparam int unsigned T = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1, run = 1'b0, load = 1'b0, alarm_en = 1'b0;
  logic [4:0] load_hours = '0, alarm_hours = '0;
  logic [5:0] load_minutes = '0, load_seconds = '0, alarm_minutes = '0;

  logic [5:0] s24, m24, s12, m12;
  logic [4:0] h24, h12;
  logic       st24, dt24, al24, le24, st12, dt12, al12, le12;

  digital_clock_hms #(.TICKS_PER_SEC(T), .HOURS_PER_DAY(24)) u24 (
    .clk(clk), .reset(reset), .run(run), .load(load),
    .load_hours(load_hours), .load_minutes(load_minutes), .load_seconds(load_seconds),
    .alarm_en(alarm_en), .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
    .seconds(s24), .minutes(m24), .hours(h24),
    .sec_tick(st24), .day_tick(dt24), .alarm(al24), .load_err(le24)
  );

  digital_clock_hms #(.TICKS_PER_SEC(T), .HOURS_PER_DAY(12)) u12 (
    .clk(clk), .reset(reset), .run(run), .load(load),
    .load_hours(load_hours), .load_minutes(load_minutes), .load_seconds(load_seconds),
    .alarm_en(alarm_en), .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
    .seconds(s12), .minutes(m12), .hours(h12),
    .sec_tick(st12), .day_tick(dt12), .alarm(al12), .load_err(le12)
  );

  typedef struct {
    int unsigned h, m, s;
    bit st, dt, al, le;
  } obs_t;

  obs_t        q0[$], q1[$];
  int unsigned tod[2], presc[2];
  int unsigned hpd[2] = '{24, 12};
  int          tests = 0, fails = 0;

  // Reference: time as seconds-of-day, prescaler as a plain cycle count.
  task automatic model_edge(input int k, output obs_t o);
    bit ok;
    o = '{h: 0, m: 0, s: 0, st: 0, dt: 0, al: 0, le: 0};
    if (reset) begin
      tod[k] = 0;
      presc[k] = 0;
    end else if (load) begin
      ok = (load_seconds < 60) && (load_minutes < 60) && (load_hours < hpd[k]);
      if (ok) begin
        tod[k] = load_hours * 3600 + load_minutes * 60 + load_seconds;
        presc[k] = 0;
      end else
        o.le = 1;
    end else if (run) begin
      if (presc[k] == T - 1) begin
        presc[k] = 0;
        tod[k] = (tod[k] + 1) % (hpd[k] * 3600);
        o.st = 1;
        o.dt = (tod[k] == 0);
        o.al = alarm_en && (alarm_hours < hpd[k]) && (alarm_minutes < 60)
               && (tod[k] == alarm_hours * 3600 + alarm_minutes * 60);
      end else
        presc[k] = presc[k] + 1;
    end
    o.h = tod[k] / 3600;
    o.m = (tod[k] / 60) % 60;
    o.s = tod[k] % 60;
  endtask

  task automatic cyc(input bit r, input bit rn, input bit ld,
                     input int unsigned lh, input int unsigned lm, input int unsigned ls);
    obs_t e;
    reset = r; run = rn; load = ld;
    load_hours = 5'(lh); load_minutes = 6'(lm); load_seconds = 6'(ls);
    @(posedge clk);
    model_edge(0, e); q0.push_back(e);
    model_edge(1, e); q1.push_back(e);
    #1;
  endtask

  task automatic run_n(input int n, input bit rn);
    for (int i = 0; i < n; i++) cyc(0, rn, 0, 0, 0, 0);
  endtask

  task automatic ldt(input int unsigned h, input int unsigned m, input int unsigned s);
    cyc(0, 1, 1, h, m, s);
  endtask

  function automatic void chk(input string name, input obs_t e,
                              input int unsigned h, input int unsigned m, input int unsigned s,
                              input bit st, input bit dt, input bit al, input bit le);
    tests++;
    if (e.h != h || e.m != m || e.s != s || e.st != st || e.dt != dt || e.al != al || e.le != le) begin
      fails++;
      $display("FAIL %s t=%0t got %0d:%0d:%0d st=%0b dt=%0b al=%0b le=%0b required %0d:%0d:%0d st=%0b dt=%0b al=%0b le=%0b",
               name, $time, h, m, s, st, dt, al, le, e.h, e.m, e.s, e.st, e.dt, e.al, e.le);
    end
  endfunction

  initial begin : monitor
    obs_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("clk24", e, h24, m24, s24, st24, dt24, al24, le24);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("clk12", e, h12, m12, s12, st12, dt12, al12, le12);
      end
    end
  end

  initial begin : stimulus
    int unsigned r, h, m, s;
    #1;
    for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0, 0, 0);
    run_n(12, 1);
    run_n(6, 0);
    ldt(0, 59, 58);  run_n(10, 1);
    ldt(23, 59, 59); run_n(5, 1);
    ldt(11, 59, 59); run_n(5, 1);
    alarm_en = 1'b1; alarm_hours = 5'd7; alarm_minutes = 6'd30;
    ldt(7, 29, 59); run_n(5, 1);
    ldt(7, 30, 0);  run_n(8, 1);
    alarm_hours = 5'd6; alarm_minutes = 6'd60;
    ldt(6, 59, 59); run_n(5, 1);
    alarm_en = 1'b0; alarm_hours = 5'd7; alarm_minutes = 6'd30;
    ldt(7, 29, 59); run_n(5, 1);
    ldt(24, 0, 0); run_n(2, 1);
    ldt(7, 60, 0); ldt(5, 6, 60); run_n(1, 1);
    ldt(1, 2, 3); run_n(3, 1);
    ldt(5, 6, 7); run_n(6, 1);
    ldt(0, 0, 0); run_n(2, 1);
    cyc(1, 1, 0, 0, 0, 0); run_n(6, 1);
    cyc(1, 1, 1, 3, 3, 3); run_n(2, 1);
    cyc(0, 0, 1, 10, 59, 59); run_n(3, 0); run_n(5, 1);

    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) begin
        alarm_en = 1'($urandom_range(0, 1));
        alarm_hours = 5'($urandom_range(0, 24));
        alarm_minutes = 6'($urandom_range(1, 60));
      end
      r = $urandom_range(0, 99);
      if (r < 1)
        cyc(1, 1, 0, 0, 0, 0);
      else if (r < 6) begin
        if ($urandom_range(0, 2) == 0) begin
          h = alarm_hours; m = alarm_minutes - 1; s = $urandom_range(56, 59);
        end else begin
          h = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 25) : $urandom_range(0, 11);
          m = ($urandom_range(0, 3) == 0) ? 59 : $urandom_range(0, 61);
          s = ($urandom_range(0, 3) == 0) ? 58 : $urandom_range(0, 61);
        end
        cyc(0, 1'($urandom_range(0, 1)), 1, h, m, s);
      end else
        cyc(0, (r < 90), 0, 0, 0, 0);
    end

    run_n(2, 1);
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
